// File: rtl/histo_frame_sequencer.sv
// Purpose: per-frame controller for the 256-bin grey histogram (accumulate, drain, copy sweep, bin clear).
// Latency: 1-cycle registered control; copy data lags oRd_Addr by the 1-cycle bin RAM read; sweep is SETTLE_CYC+2*BINS+2 cycles.
// Backpressure: none; a frame that starts while the sweep is busy is dropped and flagged on sticky oOverrun.
// Optional feature macro: HISTO_SEQ_PEAK_EN (peak bin/count tracking during COPY).
module histo_frame_sequencer #(
    parameter int BINS       = 256,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 20,
    parameter int SETTLE_CYC = 4
) (
    input  logic              iPclk,
    input  logic              iRst,
    input  logic              iFval,
    input  logic [CNT_W-1:0]  iThresh_Level,
    input  logic [CNT_W-1:0]  iBin_Q,
    output logic              oAcc_En,
    output logic [ADDR_W-1:0] oRd_Addr,
    output logic              oCopy_Wen,
    output logic [ADDR_W-1:0] oCopy_Addr,
    output logic [CNT_W-1:0]  oCopy_Data,
    output logic [CNT_W-1:0]  oCum_Data,
    output logic              oClr_Wen,
    output logic [ADDR_W-1:0] oClr_Addr,
    output logic [ADDR_W-1:0] oThresh,
    output logic              oFrame_Done,
    output logic              oOverrun,
    output logic [ADDR_W-1:0] oPeak_Bin,
    output logic [CNT_W-1:0]  oPeak_Cnt,
    output logic [2:0]        oState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_SETTLE = 3'd2,
        S_COPY   = 3'd3,
        S_CLEAR  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // The counter needs one extra bit so COPY can reach BINS (trailing read-latency cycle).
    localparam logic [ADDR_W:0]   CNT_LAST_BIN = (ADDR_W+1)'(BINS - 1);
    localparam logic [ADDR_W:0]   CNT_BINS     = (ADDR_W+1)'(BINS);
    localparam logic [ADDR_W:0]   CNT_SETTLE   = (ADDR_W+1)'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(BINS - 1);

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic              fvalQ;
    logic              fromReset;
    logic [CNT_W-1:0]  level;
    logic [CNT_W-1:0]  cumReg;
    logic [ADDR_W-1:0] thrCap;
    logic              thrFound;
    logic              accEn;
    logic [ADDR_W-1:0] rdAddr;
    logic              copyWen;
    logic [ADDR_W-1:0] copyAddr;
    logic              clrWen;
    logic [ADDR_W-1:0] clrAddr;
    logic [ADDR_W-1:0] thresh;
    logic              frameDone;
    logic              overrun;

    logic              fvalRise;
    logic              fvalFall;
    logic [CNT_W:0]    cumSum;
    logic [CNT_W-1:0]  cumNext;
    logic              sweepBusy;

    assign fvalRise  = iFval & ~fvalQ;
    assign fvalFall  = ~iFval & fvalQ;
    assign sweepBusy = (state == S_SETTLE) || (state == S_COPY) ||
                       (state == S_CLEAR)  || (state == S_DONE);

    // Running cumulative with saturation; valid only in the cycle the read data arrives.
    assign cumSum  = {1'b0, cumReg} + {1'b0, iBin_Q};
    assign cumNext = cumSum[CNT_W] ? {CNT_W{1'b1}} : cumSum[CNT_W-1:0];

    // Frame-valid history; kept running through reset so a frame already in progress never looks like a new edge.
    always_ff @(posedge iPclk) begin
        fvalQ <= iFval;
    end

    // Sequencer FSM with all control outputs registered alongside the state.
    always_ff @(posedge iPclk) begin
        if (iRst) begin
            state     <= S_CLEAR;
            cnt       <= '0;
            fromReset <= 1'b1;
            level     <= '0;
            cumReg    <= '0;
            thrCap    <= '0;
            thrFound  <= 1'b0;
            accEn     <= 1'b0;
            rdAddr    <= '0;
            copyWen   <= 1'b0;
            copyAddr  <= '0;
            clrWen    <= 1'b1;
            clrAddr   <= '0;
            thresh    <= '0;
            frameDone <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frameDone <= 1'b0;

            if (fvalRise && sweepBusy) begin
                overrun <= 1'b1;
            end

            // Fold each arriving bin into the cumulative and catch the first crossing.
            if (copyWen) begin
                cumReg <= cumNext;
                if (!thrFound && (cumNext > level)) begin
                    thrCap   <= copyAddr;
                    thrFound <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (fvalRise) begin
                        state <= S_ACCUM;
                        accEn <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (fvalFall) begin
                        state <= S_SETTLE;
                        accEn <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_SETTLE) begin
                        state    <= S_COPY;
                        cnt      <= '0;
                        rdAddr   <= '0;
                        level    <= iThresh_Level;
                        cumReg   <= '0;
                        thrCap   <= ADDR_LAST;
                        thrFound <= 1'b0;
                    end else begin
                        cnt <= cnt + (ADDR_W+1)'(1);
                    end
                end
                S_COPY: begin
                    if (cnt == CNT_BINS) begin
                        state   <= S_CLEAR;
                        cnt     <= '0;
                        copyWen <= 1'b0;
                        clrWen  <= 1'b1;
                        clrAddr <= '0;
                    end else begin
                        cnt      <= cnt + (ADDR_W+1)'(1);
                        rdAddr   <= cnt[ADDR_W-1:0] + ADDR_W'(1);
                        copyWen  <= 1'b1;
                        copyAddr <= cnt[ADDR_W-1:0];
                    end
                end
                S_CLEAR: begin
                    if (cnt == CNT_LAST_BIN) begin
                        clrWen <= 1'b0;
                        cnt    <= '0;
                        if (fromReset) begin
                            state     <= S_IDLE;
                            fromReset <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            frameDone <= 1'b1;
                            thresh    <= thrCap;
                        end
                    end else begin
                        cnt     <= cnt + (ADDR_W+1)'(1);
                        clrAddr <= clrAddr + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HISTO_SEQ_PEAK_EN
    logic              copyStart;
    logic              doneStart;
    logic [ADDR_W-1:0] peakBinTrk;
    logic [CNT_W-1:0]  peakCntTrk;
    logic [ADDR_W-1:0] peakBinOut;
    logic [CNT_W-1:0]  peakCntOut;

    assign copyStart = (state == S_SETTLE) && (cnt == CNT_SETTLE);
    assign doneStart = (state == S_CLEAR) && (cnt == CNT_LAST_BIN) && !fromReset;

    // Peak tracker: strict greater-than keeps the lowest index on ties; published with oThresh.
    always_ff @(posedge iPclk) begin
        if (iRst) begin
            peakBinTrk <= '0;
            peakCntTrk <= '0;
            peakBinOut <= '0;
            peakCntOut <= '0;
        end else begin
            if (copyStart) begin
                peakBinTrk <= '0;
                peakCntTrk <= '0;
            end else if (copyWen && (iBin_Q > peakCntTrk)) begin
                peakBinTrk <= copyAddr;
                peakCntTrk <= iBin_Q;
            end
            if (doneStart) begin
                peakBinOut <= peakBinTrk;
                peakCntOut <= peakCntTrk;
            end
        end
    end

    assign oPeak_Bin = peakBinOut;
    assign oPeak_Cnt = peakCntOut;
`else
    assign oPeak_Bin = '0;
    assign oPeak_Cnt = '0;
`endif

    assign oAcc_En     = accEn;
    assign oRd_Addr    = rdAddr;
    assign oCopy_Wen   = copyWen;
    assign oCopy_Addr  = copyAddr;
    assign oCopy_Data  = copyWen ? iBin_Q : '0;
    assign oCum_Data   = copyWen ? cumNext : '0;
    assign oClr_Wen    = clrWen;
    assign oClr_Addr   = clrAddr;
    assign oThresh     = thresh;
    assign oFrame_Done = frameDone;
    assign oOverrun    = overrun;
    assign oState      = state;

endmodule

// File: tb/tb_histo_frame_sequencer.sv
module tb_histo_frame_sequencer;

    localparam int BINS   = 256;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 20;
    localparam longint MAXC = (64'd1 << CNT_W) - 1;

    logic              iPclk = 1'b0;
    logic              iRst;
    logic              iFval;
    logic [CNT_W-1:0]  iThresh_Level;
    logic [CNT_W-1:0]  iBin_Q;
    logic              oAcc_En;
    logic [ADDR_W-1:0] oRd_Addr;
    logic              oCopy_Wen;
    logic [ADDR_W-1:0] oCopy_Addr;
    logic [CNT_W-1:0]  oCopy_Data;
    logic [CNT_W-1:0]  oCum_Data;
    logic              oClr_Wen;
    logic [ADDR_W-1:0] oClr_Addr;
    logic [ADDR_W-1:0] oThresh;
    logic              oFrame_Done;
    logic              oOverrun;
    logic [ADDR_W-1:0] oPeak_Bin;
    logic [CNT_W-1:0]  oPeak_Cnt;
    logic [2:0]        oState;

    histo_frame_sequencer dut (
        .iPclk(iPclk), .iRst(iRst), .iFval(iFval), .iThresh_Level(iThresh_Level),
        .iBin_Q(iBin_Q), .oAcc_En(oAcc_En), .oRd_Addr(oRd_Addr), .oCopy_Wen(oCopy_Wen),
        .oCopy_Addr(oCopy_Addr), .oCopy_Data(oCopy_Data), .oCum_Data(oCum_Data),
        .oClr_Wen(oClr_Wen), .oClr_Addr(oClr_Addr), .oThresh(oThresh),
        .oFrame_Done(oFrame_Done), .oOverrun(oOverrun), .oPeak_Bin(oPeak_Bin),
        .oPeak_Cnt(oPeak_Cnt), .oState(oState)
    );

    always #5 iPclk = ~iPclk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  data;
        logic [CNT_W-1:0]  cum;
    } copy_t;

    logic [CNT_W-1:0]  binMem [BINS];
    copy_t             copyQ[$];
    logic [ADDR_W-1:0] clrQ[$];
    logic [ADDR_W-1:0] expThr;
    logic [ADDR_W-1:0] expPeakBin;
    logic [CNT_W-1:0]  expPeakCnt;
    logic [ADDR_W-1:0] ramAddr;

    // Bin RAM model: 1-cycle read latency.
    always @(posedge iPclk) begin
        ramAddr = oRd_Addr;
        #1 iBin_Q = binMem[ramAddr];
    end

    // Reference model for one sweep; pushes expected copy writes and records threshold/peak.
    task automatic build_expect(input logic [CNT_W-1:0] lvl);
        longint cum = 0;
        bit found = 0;
        copy_t e;
        copyQ.delete();
        expThr = ADDR_W'(BINS - 1);
        expPeakBin = '0;
        expPeakCnt = '0;
        for (int k = 0; k < BINS; k++) begin
            cum = cum + longint'(binMem[k]);
            if (cum > MAXC) cum = MAXC;
            e.addr = ADDR_W'(k);
            e.data = binMem[k];
            e.cum  = CNT_W'(cum);
            copyQ.push_back(e);
            if (!found && cum > longint'(lvl)) begin
                expThr = ADDR_W'(k);
                found = 1;
            end
            if (binMem[k] > expPeakCnt) begin
                expPeakCnt = binMem[k];
                expPeakBin = ADDR_W'(k);
            end
        end
    endtask

    // Drives one frame of nHigh cycles plus an optional second Fval pulse, then checks the whole sweep.
    task automatic run_frame(input string name, input int nHigh, input int ovStart, input int ovLen,
                             input logic [CNT_W-1:0] lvl);
        int accCnt = 0, settleCnt = 0, copyCyc = 0, clrCnt = 0, doneCnt = 0, badMutex = 0;
        int doneCyc = -1, cyc = 0, badCopy = 0;
        copy_t e;
        iThresh_Level = lvl;
        build_expect(lvl);
        while (cyc < nHigh + 800 && !(doneCyc >= 0 && cyc > doneCyc + 3)) begin
            @(posedge iPclk);
            #1;
            iFval = (cyc < nHigh) || (ovStart >= 0 && cyc >= ovStart && cyc < ovStart + ovLen);
            @(negedge iPclk);
            accCnt    += int'(oAcc_En);
            settleCnt += int'(oState == 3'd2);
            copyCyc   += int'(oState == 3'd3);
            clrCnt    += int'(oClr_Wen);
            if (int'(oAcc_En) + int'(oCopy_Wen) + int'(oClr_Wen) > 1) badMutex++;
            if (oCopy_Wen) begin
                if (copyQ.size() == 0) begin
                    badCopy++;
                end else begin
                    e = copyQ.pop_front();
                    checks++;
                    if (oCopy_Addr !== e.addr || oCopy_Data !== e.data || oCum_Data !== e.cum) begin
                        errors++;
                        $display("FAIL %s copy: got addr %0d data %0d cum %0d, want addr %0d data %0d cum %0d",
                                 name, oCopy_Addr, oCopy_Data, oCum_Data, e.addr, e.data, e.cum);
                    end
                end
            end
            if (oFrame_Done) begin
                doneCnt++;
                doneCyc = cyc;
                checks++;
                if (oThresh !== expThr) begin
                    errors++;
                    $display("FAIL %s thresh: got %0d want %0d", name, oThresh, expThr);
                end
`ifdef HISTO_SEQ_PEAK_EN
                checks++;
                if (oPeak_Bin !== expPeakBin || oPeak_Cnt !== expPeakCnt) begin
                    errors++;
                    $display("FAIL %s peak: got %0d/%0d want %0d/%0d", name, oPeak_Bin, oPeak_Cnt, expPeakBin, expPeakCnt);
                end
`else
                checks++;
                if (oPeak_Bin !== '0 || oPeak_Cnt !== '0) begin
                    errors++;
                    $display("FAIL %s peak_off: got %0d/%0d want 0/0", name, oPeak_Bin, oPeak_Cnt);
                end
`endif
            end
            cyc++;
        end
        checks++;
        if (doneCnt != 1 || copyQ.size() != 0 || badCopy != 0) begin
            errors++;
            $display("FAIL %s completion: got done %0d leftover %0d extra %0d, want 1/0/0",
                     name, doneCnt, copyQ.size(), badCopy);
        end
        checks++;
        if (accCnt != nHigh) begin
            errors++;
            $display("FAIL %s acc_cycles: got %0d want %0d", name, accCnt, nHigh);
        end
        checks++;
        if (settleCnt != 4 || copyCyc != BINS + 1 || clrCnt != BINS) begin
            errors++;
            $display("FAIL %s phase_lengths: got settle %0d copy %0d clear %0d want 4/257/256",
                     name, settleCnt, copyCyc, clrCnt);
        end
        checks++;
        if (badMutex != 0 || oState !== 3'd0) begin
            errors++;
            $display("FAIL %s mutex_idle: got overlaps %0d state %0d want 0/0", name, badMutex, oState);
        end
    endtask

    task automatic test_reset();
        int clrCnt = 0, accSeen = 0, doneSeen = 0, badAddr = 0;
        logic [ADDR_W-1:0] a;
        iRst = 1'b1;
        iFval = 1'b0;
        iThresh_Level = '0;
        repeat (2) @(posedge iPclk);
        #1;
        checks++;
        if (oClr_Wen !== 1'b1 || oClr_Addr !== '0 || oAcc_En !== 1'b0 || oCopy_Wen !== 1'b0 ||
            oFrame_Done !== 1'b0 || oThresh !== '0 || oOverrun !== 1'b0 || oState !== 3'd4 ||
            oCum_Data !== '0 || oPeak_Bin !== '0 || oPeak_Cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got clr %0b addr %0d acc %0b cwen %0b done %0b thr %0d ovr %0b state %0d, want 1 0 0 0 0 0 0 4",
                     oClr_Wen, oClr_Addr, oAcc_En, oCopy_Wen, oFrame_Done, oThresh, oOverrun, oState);
        end
        iRst = 1'b0;
        for (int i = 0; i < BINS; i++) clrQ.push_back(ADDR_W'(i));
        for (int i = 0; i < 300; i++) begin
            @(negedge iPclk);
            accSeen  += int'(oAcc_En);
            doneSeen += int'(oFrame_Done);
            if (oClr_Wen) begin
                clrCnt++;
                if (clrQ.size() == 0) badAddr++;
                else begin
                    a = clrQ.pop_front();
                    if (oClr_Addr !== a) badAddr++;
                end
            end
        end
        checks++;
        if (clrCnt != BINS || badAddr != 0 || clrQ.size() != 0) begin
            errors++;
            $display("FAIL reset_clear: got %0d strobes %0d bad addrs, want 256 strobes 0 bad", clrCnt, badAddr);
        end
        checks++;
        if (oState !== 3'd0 || accSeen != 0 || doneSeen != 0) begin
            errors++;
            $display("FAIL reset_idle: got state %0d acc %0d done %0d want 0/0/0", oState, accSeen, doneSeen);
        end
    endtask

    task automatic test_random_bins();
        longint total = 0;
        for (int k = 0; k < BINS; k++) begin
            binMem[k] = CNT_W'($urandom_range(0, 5000));
            total += longint'(binMem[k]);
        end
        run_frame("random", 100, -1, 0, CNT_W'(total / 2));
    endtask

    task automatic test_uniform();
        for (int k = 0; k < BINS; k++) binMem[k] = CNT_W'(1000);
        run_frame("uniform", 30, -1, 0, CNT_W'(192000));
    endtask

    task automatic test_zero();
        for (int k = 0; k < BINS; k++) binMem[k] = '0;
        run_frame("zero", 10, -1, 0, '0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < BINS; k++) binMem[k] = '0;
        binMem[0] = CNT_W'(MAXC);
        binMem[1] = CNT_W'(5);
        run_frame("saturate", 12, -1, 0, CNT_W'(MAXC));
    endtask

    task automatic test_overrun();
        for (int k = 0; k < BINS; k++) binMem[k] = CNT_W'(k);
        run_frame("overrun", 20, 100, 50, CNT_W'(10000));
        checks++;
        if (oOverrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %0b want 1", oOverrun);
        end
    endtask

    task automatic test_reset_mid_copy();
        int waitCyc = 0, doneSeen = 0;
        iFval = 1'b1;
        repeat (10) @(posedge iPclk);
        #1 iFval = 1'b0;
        while (oState !== 3'd3 && waitCyc < 100) begin
            @(posedge iPclk);
            #1 waitCyc++;
        end
        checks++;
        if (oState !== 3'd3) begin
            errors++;
            $display("FAIL midcopy_reach: got state %0d want 3", oState);
        end
        repeat (20) @(posedge iPclk);
        #1 iRst = 1'b1;
        @(posedge iPclk);
        #1;
        checks++;
        if (oState !== 3'd4 || oClr_Wen !== 1'b1 || oClr_Addr !== '0 || oOverrun !== 1'b0 || oCopy_Wen !== 1'b0) begin
            errors++;
            $display("FAIL midcopy_reset: got state %0d clr %0b addr %0d ovr %0b cwen %0b want 4 1 0 0 0",
                     oState, oClr_Wen, oClr_Addr, oOverrun, oCopy_Wen);
        end
        iRst = 1'b0;
        waitCyc = 0;
        while (oState !== 3'd0 && waitCyc < 400) begin
            @(negedge iPclk);
            doneSeen += int'(oFrame_Done);
            waitCyc++;
        end
        checks++;
        if (oState !== 3'd0 || doneSeen != 0) begin
            errors++;
            $display("FAIL midcopy_recover: got state %0d done %0d want 0/0", oState, doneSeen);
        end
    endtask

    initial begin
        iRst = 1'b1;
        iFval = 1'b0;
        iBin_Q = '0;
        iThresh_Level = '0;
        for (int k = 0; k < BINS; k++) binMem[k] = '0;
        test_reset();
        test_random_bins();
        test_uniform();
        test_zero();
        test_saturate();
        test_overrun();
        test_reset_mid_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/histo_frame_sequencer.md
Name: histo_frame_sequencer

Overview:
- Per-frame controller for the 256-bin grey histogram datapath.
- Grants pixel accumulation to the bin RAM while the frame is active.
- At frame end, drains the accumulator pipeline, sweeps the bins to feed the display and cumulative RAMs, computes the cumulative threshold bin, then clears the bin RAM for the next frame.
- Sits between the camera timing signals and the three histogram RAMs; it owns their address, write-enable and phase control.

Parameters:
BINS, 256, number of histogram bins (power of two)
ADDR_W, 8, bin address width, log2(BINS)
CNT_W, 20, bin count and cumulative width
SETTLE_CYC, 4, drain cycles after frame end before the sweep

Ports:
iPclk  in  1  pixel clock
iRst  in  1  synchronous active-high reset
iFval  in  1  frame valid, high while the frame is active
iThresh_Level  in  CNT_W  cumulative threshold, latched on entering COPY
iBin_Q  in  CNT_W  bin RAM read data, 1-cycle read latency
oAcc_En  out  1  accumulator may write the bin RAM
oRd_Addr  out  ADDR_W  bin RAM read address during COPY
oCopy_Wen  out  1  write strobe for the display and cumulative RAMs
oCopy_Addr  out  ADDR_W  write address for the display and cumulative RAMs
oCopy_Data  out  CNT_W  bin count to the display RAM
oCum_Data  out  CNT_W  running cumulative value to the cumulative RAM
oClr_Wen  out  1  bin RAM clear strobe (write data 0)
oClr_Addr  out  ADDR_W  bin RAM clear address
oThresh  out  ADDR_W  threshold bin of the last completed frame
oFrame_Done  out  1  one-cycle pulse when a frame's sweep completes
oOverrun  out  1  sticky; a frame started while the sweep was busy
oPeak_Bin  out  ADDR_W  index of the largest bin (optional feature)
oPeak_Cnt  out  CNT_W  count of the largest bin (optional feature)
oState  out  3  current state, for debug

Behaviour:
- Reset (iRst=1 at a clock edge):
  - State is CLEAR with the counter at 0.
  - All outputs are 0 except oClr_Wen, which is 1 on the first CLEAR cycle.
  - oThresh is 0, oOverrun is 0, and the cumulative register is 0.
  - Reset asserted mid-sweep aborts immediately and restarts CLEAR.
- Fval edges: iFval is registered once; a rising or falling edge is the difference between the current and previous sample.
- CLEAR:
  - oClr_Wen=1, oClr_Addr = counter 0..BINS-1, one address per cycle, BINS cycles total.
  - Goes to DONE, or to IDLE when CLEAR was entered from reset.
  - No oFrame_Done pulse is generated after reset.
- IDLE:
  - Waits for a rising edge of iFval, then goes to ACCUM.
  - If iFval is already high when IDLE is entered, there is no accumulation until the next rising edge; partial frames are never counted.
- ACCUM:
  - oAcc_En=1.
  - On a falling edge of iFval, oAcc_En drops on the next cycle and the state goes to SETTLE.
- SETTLE: waits SETTLE_CYC cycles, then goes to COPY. iThresh_Level is latched and the cumulative register cleared on entry to COPY.
- COPY:
  - oRd_Addr = 0..BINS-1 over BINS cycles, plus 1 trailing cycle (BINS+1 cycles total).
  - Read data for address k arrives 1 cycle later. In that cycle:
    - oCopy_Wen=1 and oCopy_Addr=k.
    - oCopy_Data = iBin_Q.
    - oCum_Data = previous cumulative + iBin_Q, saturating at 2^CNT_W-1.
  - Threshold: the first k where oCum_Data > the latched level is captured. If no bin crosses, the result is BINS-1.
  - Goes to CLEAR after the last write.
- DONE:
  - oThresh is updated to the captured threshold bin.
  - oFrame_Done=1 for exactly one cycle, then the state goes to IDLE.
- Overrun:
  - A rising edge of iFval in SETTLE, COPY, CLEAR or DONE sets oOverrun, which stays set until reset.
  - That frame is skipped and the sweep always completes.
- Mutual exclusion: oAcc_En, oCopy_Wen and oClr_Wen are never high in the same cycle.
- State encoding: IDLE=0, ACCUM=1, SETTLE=2, COPY=3, CLEAR=4, DONE=5.
- Sweep length per frame: SETTLE_CYC + BINS+1 + BINS + 1 cycles = 518 with defaults.

Optional Feature:
HISTO_SEQ_PEAK_EN
- Defined:
  - During COPY, tracks the maximum iBin_Q and its bin index.
  - Ties go to the lowest index.
  - oPeak_Bin and oPeak_Cnt update in DONE together with oThresh and reset to 0.
- Undefined: oPeak_Bin and oPeak_Cnt are constant 0 and no tracking logic is built.

Test Plan:
- Reset for 2 cycles, then release:
  - oClr_Wen high for 256 cycles, oClr_Addr 0..255, then oState=0.
  - No oFrame_Done pulse; oAcc_En stays 0.
- After IDLE, iFval high for 100 cycles, then low:
  - oAcc_En high for those cycles (1-cycle lag).
  - 4 SETTLE cycles, 257 COPY cycles with 256 oCopy_Wen pulses at addresses 0..255, 256 CLEAR cycles, one oFrame_Done pulse.
- iBin_Q=1000 for every bin, iThresh_Level=192000:
  - oCum_Data at k=191 is 192000; at k=192 it is 193000.
  - oThresh=192 after DONE.
- iBin_Q=0 for all bins: oThresh=255.
- iBin_Q=2^20-1 at bin 0 plus 5 at bin 1: oCum_Data saturates at 1048575 at bin 1; with HISTO_SEQ_PEAK_EN, oPeak_Bin=0 and oPeak_Cnt=1048575.
- iFval rising during COPY:
  - oOverrun=1 and the sweep completes.
  - The skipped frame produces no accumulation.
  - iRst mid-COPY restarts CLEAR at oClr_Addr=0 and clears oOverrun.
